multi_buffer: RTL and testbench
===============================

# multi_buffer

Parametrised single-clock buffering block that collects words from CHANNELS independent producers (Fibonacci, Timer and future generators), stores each in its own FIFO, and drains them round-robin onto one consumer port with a valid/ready handshake. It sits between the generator blocks and the display/consumer logic. It extends the single-buffer design with configurable width, depth and channel count, per-channel almost-full and sticky overflow flags, and consumer backpressure.

## Interface
- WIDTH, 16, data word width
- DEPTH, 8, words per channel FIFO; power of two, >= 2
- CHANNELS, 2, number of producer channels, >= 1
- AFULL_TH, 6, per-channel count at or above which buffer_afull asserts; 1..DEPTH
- CH_W, max(1, $clog2(CHANNELS)), derived width of the channel index
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- data_in_en  in  CHANNELS  per-channel write strobe; word valid this cycle
- data_in  in  CHANNELS*WIDTH  packed words; channel i at [i*WIDTH +: WIDTH]
- clr_ovf  in  1  clears all overflow flags
- data_out_ready  in  1  consumer accepts data_out this cycle
- buffer_empty  out  CHANNELS  channel FIFO holds zero words
- buffer_full  out  CHANNELS  channel FIFO holds DEPTH words
- buffer_afull  out  CHANNELS  channel count >= AFULL_TH
- overflow  out  CHANNELS  sticky: a write to a full channel was dropped
- data_out_valid  out  1  data_out holds a valid word
- data_out  out  WIDTH  current output word
- data_out_ch  out  CH_W  channel index the current word came from

## Operation
- Reset (rst low, asynchronous): all pointers and counts 0; buffer_empty all 1; buffer_full, buffer_afull, overflow all 0; data_out_valid 0; data_out 0; data_out_ch 0; round-robin pointer set to CHANNELS-1, so channel 0 has first priority.
- Write: channel i accepts data_in_en[i] if not full, or if full and popped in the same cycle. If full and not popped, the word is dropped and overflow[i] is set.
- overflow[i] clears on clr_ovf. If clr_ovf and a new drop happen in the same cycle, set wins.
- Output stage is one register. It loads when data_out_valid is 0 or data_out_ready is 1 (a transfer happens on valid && ready).
- On load, the arbiter grants the first non-empty channel searching from last_grant+1, wrapping modulo CHANNELS. It pops that channel, loads data_out/data_out_ch, and updates last_grant. If all channels are empty, data_out_valid goes 0 and data_out holds its value.
- While valid && !ready: data_out, data_out_ch and valid stay stable, and no pop occurs.
- Write and pop on the same channel in the same cycle: count unchanged, both take effect.
- Count width is $clog2(DEPTH+1). Pointers are $clog2(DEPTH) bits and wrap naturally.
- Per-channel order is preserved. There is no ordering guarantee across channels beyond round-robin.

## Timing
- A write sampled at edge E0 updates count and flags, visible after E0.
- An empty FIFO with an idle output stage gives data_out_valid high after E1, so minimum latency is 2 cycles from data_in_en to data_out_valid.
- Flags are registered functions of count and change on the edge after the write or pop.
- Sustained throughput is one word per cycle total while data_out_ready stays high.
- Asynchronous reset clears state immediately. Deassertion is synchronised externally.

## Structure
- Package multi_buffer_pkg holds default WIDTH/DEPTH/CHANNELS constants and a clog2-safe CH_W function.
- Sub-module sync_fifo (WIDTH, DEPTH, AFULL_TH): storage, pointers, count, empty/full/afull, and overflow handling. It is instantiated CHANNELS times via generate.
- The top level contains the round-robin arbiter, pop decode and output register.

## Test plan
- Reset: hold rst low mid-idle, then release -> buffer_empty=2'b11, full=0, overflow=0, data_out_valid=0, data_out=0.
- Single word: ready=1, ch0 writes 16'h0001 at E0 -> data_out_valid=1, data_out=16'h0001, data_out_ch=0 after E1; valid=0 the next cycle.
- Fairness: ready=1, both channels write 4 words back-to-back (ch0 16'h0000..0003, ch1 16'h1000..1003) -> output sequence 0000,1000,0001,1001,0002,1002,0003,1003.
- Overflow: ready=0, DEPTH=8, ch0 writes 10 words -> word 1 sits in the output register, words 2..9 fill the FIFO, buffer_full[0]=1, afull asserts after the 7th write, word 10 is dropped, overflow[0]=1. A clr_ovf pulse then gives overflow[0]=0.
- Backpressure: ch1 streams 16'h2000..200F while ready toggles pseudo-randomly -> data_out is stable while valid && !ready, all 16 words arrive in order, and there is no overflow.
- Reset mid-operation: ch0 holds 5 words with valid=1, then rst goes low between edges -> outputs take their reset values immediately. After release, no stale words are emitted.

Source files
------------

// File: rtl/multi_buffer_pkg.sv
// multi_buffer shared definitions.
// Default geometry and channel-index width helper.
package multi_buffer_pkg;

   localparam int WIDTH_DEF    = 16;
   localparam int DEPTH_DEF    = 8;
   localparam int CHANNELS_DEF = 2;
   localparam int AFULL_TH_DEF = 6;

   // Channel index width; a single channel still needs one bit.
   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Per-channel FIFO with registered occupancy flags.
// Drops writes to a full FIFO and records a sticky overflow.
module sync_fifo
   import multi_buffer_pkg::*;
#(
   parameter int WIDTH    = WIDTH_DEF,
   parameter int DEPTH    = DEPTH_DEF,
   parameter int AFULL_TH = AFULL_TH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   input  logic             clr_ovf,
   output logic             empty,
   output logic             full,
   output logic             afull,
   output logic             overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_C = CW'(AFULL_TH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_nxt;
   logic             rd_ok;
   logic             wr_ok;
   logic             drop;

   // A pop frees a slot in the same cycle, so full+pop still accepts.
   assign rd_ok   = rd_en && !empty;
   assign wr_ok   = wr_en && (!full || rd_ok);
   assign drop    = wr_en && full && !rd_ok;
   assign rd_data = mem[rd_ptr];

   // Next occupancy; simultaneous push and pop leave it unchanged.
   always_comb begin
      count_nxt = count;
      unique case (1'b1)
         (wr_ok && !rd_ok): count_nxt = count + CW'(1);
         (rd_ok && !wr_ok): count_nxt = count - CW'(1);
         default: count_nxt = count;
      endcase
   end

   // Storage write; contents need no reset.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= wr_data;
   end

   // Pointers, count, flags and sticky overflow.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         empty    <= 1'b1;
         full     <= 1'b0;
         afull    <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
         if (rd_ok) rd_ptr <= rd_ptr + PW'(1);
         count <= count_nxt;
         empty <= (count_nxt == '0);
         full  <= (count_nxt == DEPTH_C);
         afull <= (count_nxt >= AFULL_C);
         if (drop)
            overflow <= 1'b1;
         else if (clr_ovf)
            overflow <= 1'b0;
      end
   end

endmodule

// File: rtl/multi_buffer.sv
// Multi-channel buffer: per-channel FIFOs drained round-robin
// into one registered valid/ready output stage.
module multi_buffer
   import multi_buffer_pkg::*;
#(
   parameter int WIDTH    = WIDTH_DEF,
   parameter int DEPTH    = DEPTH_DEF,
   parameter int CHANNELS = CHANNELS_DEF,
   parameter int AFULL_TH = AFULL_TH_DEF,
   parameter int CH_W     = ch_w(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS-1:0]       data_in_en,
   input  logic [CHANNELS*WIDTH-1:0] data_in,
   input  logic                      clr_ovf,
   input  logic                      data_out_ready,
   output logic [CHANNELS-1:0]       buffer_empty,
   output logic [CHANNELS-1:0]       buffer_full,
   output logic [CHANNELS-1:0]       buffer_afull,
   output logic [CHANNELS-1:0]       overflow,
   output logic                      data_out_valid,
   output logic [WIDTH-1:0]          data_out,
   output logic [CH_W-1:0]           data_out_ch
);

   logic [CHANNELS-1:0] pop;
   logic [WIDTH-1:0]    rd_data [CHANNELS];
   logic [CH_W-1:0]     last_grant;
   logic [CH_W-1:0]     grant;
   logic [CH_W-1:0]     cand;
   logic                found;
   logic                load;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      sync_fifo #(
         .WIDTH    (WIDTH),
         .DEPTH    (DEPTH),
         .AFULL_TH (AFULL_TH)
      ) u_fifo (
         .clk      (clk),
         .rst      (rst),
         .wr_en    (data_in_en[i]),
         .wr_data  (data_in[i*WIDTH +: WIDTH]),
         .rd_en    (pop[i]),
         .rd_data  (rd_data[i]),
         .clr_ovf  (clr_ovf),
         .empty    (buffer_empty[i]),
         .full     (buffer_full[i]),
         .afull    (buffer_afull[i]),
         .overflow (overflow[i])
      );
   end

   // Output register may take a new word when idle or being drained.
   assign load = !data_out_valid || data_out_ready;

   // Round-robin search starting just after the last granted channel.
   always_comb begin
      found = 1'b0;
      grant = '0;
      cand  = '0;
      for (int k = 1; k <= CHANNELS; k++) begin
         cand = CH_W'((int'(last_grant) + k) % CHANNELS);
         if (!found && !buffer_empty[cand]) begin
            found = 1'b1;
            grant = cand;
         end
      end
   end

   // Pop only the granted channel, and only when the output loads.
   always_comb begin
      pop = '0;
      if (load && found) pop[grant] = 1'b1;
   end

   // Output stage and arbiter history.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_out_valid <= 1'b0;
         data_out       <= '0;
         data_out_ch    <= '0;
         last_grant     <= CH_W'(CHANNELS - 1);
      end else if (load) begin
         if (found) begin
            data_out_valid <= 1'b1;
            data_out       <= rd_data[grant];
            data_out_ch    <= grant;
            last_grant     <= grant;
         end else begin
            data_out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_multi_buffer.sv
// Directed self-checking bench for multi_buffer.
// Default geometry: WIDTH=16, DEPTH=8, CHANNELS=2, AFULL_TH=6.
module tb_multi_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  data_in_en;
   logic [31:0] data_in;
   logic        clr_ovf;
   logic        data_out_ready;
   logic [1:0]  buffer_empty;
   logic [1:0]  buffer_full;
   logic [1:0]  buffer_afull;
   logic [1:0]  overflow;
   logic        data_out_valid;
   logic [15:0] data_out;
   logic [0:0]  data_out_ch;

   int errors = 0;
   int checks = 0;

   logic [15:0] fexp [8];
   logic [63:0] rpat;
   int          rx;
   int          wx;
   logic        prev_v;
   logic        prev_r;
   logic [15:0] prev_d;

   multi_buffer dut (
      .clk            (clk),
      .rst            (rst),
      .data_in_en     (data_in_en),
      .data_in        (data_in),
      .clr_ovf        (clr_ovf),
      .data_out_ready (data_out_ready),
      .buffer_empty   (buffer_empty),
      .buffer_full    (buffer_full),
      .buffer_afull   (buffer_afull),
      .overflow       (overflow),
      .data_out_valid (data_out_valid),
      .data_out       (data_out),
      .data_out_ch    (data_out_ch)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_empty"}, 32'(buffer_empty), 32'h3);
      check({tag, "_full"},  32'(buffer_full),  32'h0);
      check({tag, "_afull"}, 32'(buffer_afull), 32'h0);
      check({tag, "_ovf"},   32'(overflow),     32'h0);
      check({tag, "_valid"}, 32'(data_out_valid), 32'h0);
      check({tag, "_data"},  32'(data_out),     32'h0);
      check({tag, "_ch"},    32'(data_out_ch),  32'h0);
   endtask

   initial begin
      rst            = 1'b1;
      data_in_en     = '0;
      data_in        = '0;
      clr_ovf        = 1'b0;
      data_out_ready = 1'b0;
      fexp = '{16'h0000, 16'h1000, 16'h0001, 16'h1001,
               16'h0002, 16'h1002, 16'h0003, 16'h1003};
      rpat = 64'hDB6D_B6DB_6DB6_DB6D;

      // Reset asserted between edges while idle
      tick();
      tick();
      #3 rst = 1'b0;
      #1 check_reset_vals("rst_async");
      tick();
      tick();
      rst = 1'b1;
      tick();
      check_reset_vals("rst_release");

      // Fairness: both channels write four words back-to-back
      data_out_ready = 1'b1;
      for (int c = 0; c < 9; c++) begin
         if (c < 4) begin
            data_in_en = 2'b11;
            data_in    = {16'h1000 + 16'(c), 16'h0000 + 16'(c)};
         end else begin
            data_in_en = 2'b00;
         end
         tick();
         if (c >= 1) begin
            check("fair_valid", 32'(data_out_valid), 32'h1);
            check("fair_data",  32'(data_out), 32'(fexp[c-1]));
            check("fair_ch",    32'(data_out_ch), 32'((c - 1) % 2));
         end
      end
      tick();
      check("fair_idle", 32'(data_out_valid), 32'h0);

      // Single word, two-cycle latency
      data_in_en = 2'b01;
      data_in    = 32'h0000_0001;
      tick();
      data_in_en = 2'b00;
      check("single_e0_empty", 32'(buffer_empty), 32'h2);
      check("single_e0_valid", 32'(data_out_valid), 32'h0);
      tick();
      check("single_valid", 32'(data_out_valid), 32'h1);
      check("single_data",  32'(data_out), 32'h0001);
      check("single_ch",    32'(data_out_ch), 32'h0);
      check("single_empty", 32'(buffer_empty), 32'h3);
      tick();
      check("single_after_valid", 32'(data_out_valid), 32'h0);
      check("single_after_hold",  32'(data_out), 32'h0001);

      // Overflow with the consumer stalled
      data_out_ready = 1'b0;
      for (int j = 1; j <= 10; j++) begin
         data_in_en = 2'b01;
         data_in    = {16'h0000, 16'h3000 + 16'(j)};
         tick();
         if (j == 6) check("ovf_afull_w6", 32'(buffer_afull), 32'h0);
         if (j == 7) check("ovf_afull_w7", 32'(buffer_afull), 32'h1);
         if (j == 8) check("ovf_full_w8", 32'(buffer_full), 32'h0);
         if (j == 9) begin
            check("ovf_full_w9", 32'(buffer_full), 32'h1);
            check("ovf_flag_w9", 32'(overflow), 32'h0);
         end
         if (j == 10) begin
            check("ovf_full_w10", 32'(buffer_full), 32'h1);
            check("ovf_flag_w10", 32'(overflow), 32'h1);
         end
      end
      check("ovf_out_valid", 32'(data_out_valid), 32'h1);
      check("ovf_out_data",  32'(data_out), 32'h3001);
      data_in    = 32'h0000_3ABC;
      clr_ovf    = 1'b1;
      tick();
      data_in_en = 2'b00;
      clr_ovf    = 1'b0;
      check("ovf_set_wins", 32'(overflow), 32'h1);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      check("ovf_cleared", 32'(overflow), 32'h0);
      check("ovf_still_full", 32'(buffer_full), 32'h1);
      data_out_ready = 1'b1;
      for (int j = 2; j <= 9; j++) begin
         tick();
         check("ovf_drain_valid", 32'(data_out_valid), 32'h1);
         check("ovf_drain_data", 32'(data_out), 32'h3000 + 32'(j));
      end
      tick();
      check("ovf_drain_idle", 32'(data_out_valid), 32'h0);
      check("ovf_drain_empty", 32'(buffer_empty), 32'h3);

      // Backpressure: ch1 stream under a toggling ready
      rx     = 0;
      wx     = 0;
      prev_v = 1'b0;
      prev_r = 1'b0;
      prev_d = '0;
      for (int c = 0; c < 100 && rx < 16; c++) begin
         if (wx < 16 && (c % 2) == 0) begin
            data_in_en = 2'b10;
            data_in    = {16'h2000 + 16'(wx), 16'h0000};
            wx++;
         end else begin
            data_in_en = 2'b00;
         end
         data_out_ready = rpat[c % 64];
         if (data_out_valid && data_out_ready) begin
            check("bp_data", 32'(data_out), 32'h2000 + 32'(rx));
            check("bp_ch",   32'(data_out_ch), 32'h1);
            rx++;
         end
         prev_v = data_out_valid;
         prev_d = data_out;
         prev_r = data_out_ready;
         tick();
         if (prev_v && !prev_r) begin
            check("bp_hold_valid", 32'(data_out_valid), 32'h1);
            check("bp_hold_data",  32'(data_out), 32'(prev_d));
         end
      end
      data_in_en = 2'b00;
      check("bp_count", 32'(rx), 32'd16);
      check("bp_no_ovf", 32'(overflow), 32'h0);

      // Reset in the middle of a stalled transfer
      data_out_ready = 1'b0;
      tick();
      tick();
      for (int j = 1; j <= 6; j++) begin
         data_in_en = 2'b01;
         data_in    = {16'h0000, 16'h4000 + 16'(j)};
         tick();
      end
      data_in_en = 2'b00;
      check("mid_valid", 32'(data_out_valid), 32'h1);
      check("mid_data",  32'(data_out), 32'h4001);
      check("mid_empty", 32'(buffer_empty), 32'h2);
      #3 rst = 1'b0;
      #1 check_reset_vals("mid_rst");
      tick();
      rst = 1'b1;
      data_out_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
         tick();
         check("mid_no_stale", 32'(data_out_valid), 32'h0);
         check("mid_no_stale_data", 32'(data_out), 32'h0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
